// File: rtl/dmem_arbiter.sv
// Arbitrates the single data-memory port between the pipeline MEM stage and an
// external burst port; the CPU has priority, with a starvation counter forcing ext beats.
module dmem_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int LEN_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_start,
    input  logic              ext_write,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_beat,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_busy,
    output logic              ext_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ext_write_q;
    logic [SW-1:0]     starve_cnt;

    logic in_burst;
    logic cpu_act;
    logic ext_win;
    logic last_beat;

    assign in_burst  = (state_q == BURST);
    assign cpu_act   = cpu_ren | cpu_wen;
    assign ext_win   = in_burst && (!cpu_act || (starve_cnt == SW'(STARVE_MAX)));
    assign last_beat = (beat_cnt == len_q);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ext_start) state_d = BURST;
            BURST:   if (ext_win && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Port mux: the ext beat owns the port only when it wins; otherwise mem_* mirror the CPU.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wen   = cpu_wen;
        mem_ren   = cpu_ren & ~cpu_wen;
        mem_wdata = cpu_wdata;
        cpu_rdata = '0;
        ext_rdata = '0;
        ext_beat  = 1'b0;
        cpu_stall = 1'b0;
        ext_busy  = in_burst;
        ext_done  = (state_q == DONE);
        if (ext_win) begin
            mem_addr  = addr_q + (ADDR_W'(beat_cnt) << 3);
            mem_wen   = ext_write_q;
            mem_ren   = ~ext_write_q;
            mem_wdata = ext_wdata;
            ext_beat  = 1'b1;
            cpu_stall = cpu_act;
            if (!ext_write_q) ext_rdata = mem_rdata;
        end else if (cpu_ren && !cpu_wen) begin
            cpu_rdata = mem_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            beat_cnt    <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            ext_write_q <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ext_start) begin
                addr_q      <= ext_addr;
                len_q       <= ext_len;
                ext_write_q <= ext_write;
                beat_cnt    <= '0;
            end
            if (ext_win) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + LEN_W'(1);
            end
            // Count only cycles where the CPU beat a pending ext beat; saturate at the limit.
            if (!in_burst || ext_win) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SW'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: reset, idle-CPU bursts, forced beats,
// interleaved traffic, address wrap, reset mid-burst and ignored ext_start.
module tb_dmem_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 64;
    localparam int LEN_W  = 4;
    localparam logic [63:0] RD_KEY = 64'hC0DE_0000_0000_0000;

    logic              clk = 1'b0;
    logic              arst_n;
    logic              cpu_ren, cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              ext_start, ext_write;
    logic [ADDR_W-1:0] ext_addr;
    logic [LEN_W-1:0]  ext_len;
    logic [DATA_W-1:0] ext_wdata, ext_rdata;
    logic              ext_beat, ext_busy, ext_done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren, mem_wen;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Same-cycle SRAM model: read data is a fixed function of the address.
    function automatic logic [63:0] rd(input logic [63:0] a);
        return a ^ RD_KEY;
    endfunction

    assign mem_rdata = mem_ren ? rd(mem_addr) : 64'h0;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_start(ext_start), .ext_write(ext_write), .ext_addr(ext_addr),
        .ext_len(ext_len), .ext_wdata(ext_wdata), .ext_beat(ext_beat),
        .ext_rdata(ext_rdata), .ext_busy(ext_busy), .ext_done(ext_done),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_ren   = 1'b0;
        cpu_wen   = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        ext_start = 1'b0;
        ext_write = 1'b0;
        ext_addr  = '0;
        ext_len   = '0;
        ext_wdata = '0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  ext_busy,  1'b0);
        check({tag, "_done"},  ext_done,  1'b0);
        check({tag, "_beat"},  ext_beat,  1'b0);
        check({tag, "_stall"}, cpu_stall, 1'b0);
        check({tag, "_ren"},   mem_ren,   1'b0);
        check({tag, "_wen"},   mem_wen,   1'b0);
        check({tag, "_addr"},  mem_addr,  64'h0);
    endtask

    initial begin
        logic [63:0] exp_addr;
        logic        ext_exp;
        logic [5:0]  t3_ren, t3_wen;
        int          beat;

        idle_inputs();
        arst_n = 1'b0;
        tick();
        tick();
        check_quiet("reset");

        // 1) Idle CPU, write burst of 4 beats at 0x100.
        arst_n    = 1'b1;
        ext_start = 1'b1;
        ext_write = 1'b1;
        ext_addr  = 64'h100;
        ext_len   = 4'd3;
        #1;
        check("t1_idle_busy", ext_busy, 1'b0);
        tick();
        ext_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ext_wdata = 64'hAAAA_0000_0000_0000 + 64'(i);
            #1;
            check("t1_beat",  ext_beat,  1'b1);
            check("t1_addr",  mem_addr,  64'h100 + 64'(8 * i));
            check("t1_wen",   mem_wen,   1'b1);
            check("t1_ren",   mem_ren,   1'b0);
            check("t1_wdata", mem_wdata, 64'hAAAA_0000_0000_0000 + 64'(i));
            check("t1_stall", cpu_stall, 1'b0);
            check("t1_done_early", ext_done, 1'b0);
            tick();
        end
        check("t1_done", ext_done, 1'b1);
        check("t1_busy_done", ext_busy, 1'b0);
        tick();
        check("t1_done_pulse", ext_done, 1'b0);

        // 2) CPU loads every cycle; read burst of 2 beats is forced every 5th cycle.
        cpu_ren   = 1'b1;
        cpu_addr  = 64'h40;
        ext_start = 1'b1;
        ext_write = 1'b0;
        ext_addr  = 64'h200;
        ext_len   = 4'd1;
        #1;
        check("t2_start_rdata", cpu_rdata, rd(64'h40));
        tick();
        ext_start = 1'b0;
        beat = 0;
        for (int c = 0; c < 10; c++) begin
            ext_exp = (c % 5 == 4);
            #1;
            check("t2_stall", cpu_stall, ext_exp);
            check("t2_beat",  ext_beat,  ext_exp);
            check("t2_cpu_rdata", cpu_rdata, ext_exp ? 64'h0 : rd(64'h40));
            if (ext_exp) begin
                exp_addr = 64'h200 + 64'(8 * beat);
                check("t2_addr",      mem_addr,  exp_addr);
                check("t2_ext_rdata", ext_rdata, rd(exp_addr));
                beat++;
            end else begin
                check("t2_ext_rdata_zero", ext_rdata, 64'h0);
            end
            tick();
        end
        cpu_ren = 1'b0;
        #1;
        check("t2_done", ext_done, 1'b1);
        tick();

        // 3) Interleaved ld / idle / sd / idle / ld+sd(illegal) / idle under a write burst.
        t3_ren = 6'b010001;
        t3_wen = 6'b010100;
        ext_start = 1'b1;
        ext_write = 1'b1;
        ext_addr  = 64'h300;
        ext_len   = 4'd2;
        tick();
        ext_start = 1'b0;
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            cpu_ren   = t3_ren[c];
            cpu_wen   = t3_wen[c];
            cpu_addr  = 64'h80 + 64'(8 * c);
            cpu_wdata = 64'h1111 * 64'(c + 1);
            ext_wdata = 64'hBBBB_0000 + 64'(c);
            ext_exp   = !(t3_ren[c] | t3_wen[c]);
            exp_addr  = ext_exp ? 64'h300 + 64'(8 * beat) : 64'h80 + 64'(8 * c);
            #1;
            check("t3_stall", cpu_stall, 1'b0);
            check("t3_beat",  ext_beat,  ext_exp);
            check("t3_addr",  mem_addr,  exp_addr);
            check("t3_wen",   mem_wen,   ext_exp | t3_wen[c]);
            check("t3_ren",   mem_ren,   !ext_exp && t3_ren[c] && !t3_wen[c]);
            check("t3_wdata", mem_wdata, ext_exp ? 64'hBBBB_0000 + 64'(c) : 64'h1111 * 64'(c + 1));
            check("t3_cpu_rdata", cpu_rdata,
                  (!ext_exp && t3_ren[c] && !t3_wen[c]) ? rd(exp_addr) : 64'h0);
            if (ext_exp) beat++;
            tick();
        end
        idle_inputs();
        #1;
        check("t3_done", ext_done, 1'b1);
        tick();

        // 4) Address wrap: second beat of a burst at the top of memory lands on 0.
        ext_start = 1'b1;
        ext_write = 1'b0;
        ext_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
        ext_len   = 4'd1;
        tick();
        ext_start = 1'b0;
        #1;
        check("t4_addr0",  mem_addr,  64'hFFFF_FFFF_FFFF_FFF8);
        check("t4_rdata0", ext_rdata, rd(64'hFFFF_FFFF_FFFF_FFF8));
        tick();
        check("t4_addr1",  mem_addr,  64'h0);
        check("t4_rdata1", ext_rdata, rd(64'h0));
        check("t4_ren1",   mem_ren,   1'b1);
        tick();
        check("t4_done", ext_done, 1'b1);
        tick();

        // 5) Reset during beat 2 of an 8-beat write burst, then a fresh burst.
        ext_start = 1'b1;
        ext_write = 1'b1;
        ext_addr  = 64'h400;
        ext_len   = 4'd7;
        tick();
        ext_start = 1'b0;
        tick();
        tick();
        check("t5_beat2_addr", mem_addr, 64'h410);
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
        check_quiet("t5_after_reset");
        tick();
        check("t5_no_done", ext_done, 1'b0);
        check("t5_no_beat", ext_beat, 1'b0);
        ext_start = 1'b1;
        ext_addr  = 64'h500;
        ext_len   = 4'd0;
        tick();
        ext_start = 1'b0;
        check("t5_new_beat", ext_beat, 1'b1);
        check("t5_new_addr", mem_addr, 64'h500);
        tick();
        check("t5_new_done", ext_done, 1'b1);
        tick();

        // 6) ext_start held high during a burst must not restart or stretch it.
        ext_start = 1'b1;
        ext_write = 1'b1;
        ext_addr  = 64'h600;
        ext_len   = 4'd2;
        tick();
        ext_addr = 64'h900;
        ext_len  = 4'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_beat", ext_beat, 1'b1);
            check("t6_addr", mem_addr, 64'h600 + 64'(8 * i));
            tick();
        end
        check("t6_done", ext_done, 1'b1);
        ext_start = 1'b0;
        tick();
        check("t6_idle_busy", ext_busy, 1'b0);
        check("t6_idle_beat", ext_beat, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
